// File: rtl/video_layer_mixer.sv
// Mixes NUM_LAYERS 1-bit video layers into RGB through a two-bank (mono/colour)
// writable palette with per-channel saturation, frame-latched inversion and
// blanking. Sync/blank signals travel through a matching 2-stage ce_pix delay.
module video_layer_mixer #(
  parameter int NUM_LAYERS  = 3,
  parameter int COLOR_DEPTH = 4
) (
  input  logic                           clk_sys,
  input  logic                           reset,
  input  logic                           ce_pix,
  input  logic                           color_mode,
  input  logic                           pal_we,
  input  logic [$clog2(NUM_LAYERS):0]    pal_addr,
  input  logic [3*COLOR_DEPTH-1:0]       pal_data,
  input  logic [NUM_LAYERS-1:0]          layer_in,
  input  logic                           invert_in,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic                           hblank_in,
  input  logic                           vblank_in,
  output logic [COLOR_DEPTH-1:0]         r_out,
  output logic [COLOR_DEPTH-1:0]         g_out,
  output logic [COLOR_DEPTH-1:0]         b_out,
  output logic                           hsync_out,
  output logic                           vsync_out,
  output logic                           hblank_out,
  output logic                           vblank_out,
  output logic                           invert_active
);

  localparam int AW = $clog2(NUM_LAYERS) + 1;
  localparam int CD = COLOR_DEPTH;
  localparam int PW = 3 * CD;
  localparam int SW = CD + $clog2(NUM_LAYERS + 1);
  localparam logic [CD-1:0] GREY_CH = CD'((2 ** (CD - 1)) - 1);
  localparam logic [PW-1:0] GREY    = {3{GREY_CH}};
  localparam logic [SW-1:0] CH_MAX  = SW'((2 ** CD) - 1);

  logic [PW-1:0] r_pal [2][NUM_LAYERS];
  logic          r_mode_q;
  logic          r_accum;
  logic [CD-1:0] r_s1 [3];
  logic [3:0]    r_sync1;          // {hsync, vsync, hblank, vblank}
  logic [SW-1:0] w_sum [3];
  logic [CD-1:0] w_mix [3];
  logic          w_frame_start;
  logic          w_blank;

  // The stage-1 vsync bit doubles as the previously sampled vsync_in.
  assign w_frame_start = ce_pix & vsync_in & ~r_sync1[2];
  assign w_blank       = r_sync1[1] | r_sync1[0];

  // Palette: written on any clk_sys cycle; out-of-range layer indices never match.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_LAYERS; i++)
          r_pal[b][i] <= GREY;
    end else if (pal_we) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_LAYERS; i++)
          if (pal_addr == AW'(b * (2 ** (AW - 1)) + i))
            r_pal[b][i] <= pal_data;
    end
  end

  // Per-channel sum of the selected bank's entries for every set layer, saturated.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      w_sum[c] = '0;
      for (int i = 0; i < NUM_LAYERS; i++)
        if (layer_in[i])
          w_sum[c] = w_sum[c] + SW'(r_pal[r_mode_q][i][(2 - c) * CD +: CD]);
      w_mix[c] = (w_sum[c] > CH_MAX) ? {CD{1'b1}} : w_sum[c][CD-1:0];
    end
  end

  // Frame-start latching of inversion and palette bank, accumulation otherwise.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      invert_active <= 1'b0;
      r_accum       <= 1'b0;
      r_mode_q      <= 1'b0;
    end else if (ce_pix) begin
      if (w_frame_start) begin
        invert_active <= r_accum | invert_in;
        r_accum       <= 1'b0;
        r_mode_q      <= color_mode;
      end else begin
        r_accum <= r_accum | invert_in;
      end
    end
  end

  // Stage 1: register mixed colour and timing together.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) r_s1[c] <= '0;
      r_sync1 <= '0;
    end else if (ce_pix) begin
      for (int c = 0; c < 3; c++) r_s1[c] <= w_mix[c];
      r_sync1 <= {hsync_in, vsync_in, hblank_in, vblank_in};
    end
  end

  // Stage 2: inversion, then blanking (blanking wins), plus second timing delay.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
      {hsync_out, vsync_out, hblank_out, vblank_out} <= '0;
    end else if (ce_pix) begin
      r_out <= w_blank ? '0 : (r_s1[0] ^ {CD{invert_active}});
      g_out <= w_blank ? '0 : (r_s1[1] ^ {CD{invert_active}});
      b_out <= w_blank ? '0 : (r_s1[2] ^ {CD{invert_active}});
      {hsync_out, vsync_out, hblank_out, vblank_out} <= r_sync1;
    end
  end

endmodule

// File: tb/tb_video_layer_mixer.sv
// Directed bench for video_layer_mixer at NUM_LAYERS=3, COLOR_DEPTH=4.
module tb_video_layer_mixer;
  logic        clk_sys = 1'b0;
  logic        reset, ce_pix, color_mode, pal_we;
  logic [2:0]  pal_addr;
  logic [11:0] pal_data;
  logic [2:0]  layer_in;
  logic        invert_in, hsync_in, vsync_in, hblank_in, vblank_in;
  logic [3:0]  r_out, g_out, b_out;
  logic        hsync_out, vsync_out, hblank_out, vblank_out, invert_active;

  int n_checks = 0;
  int n_fail   = 0;

  video_layer_mixer #(.NUM_LAYERS(3), .COLOR_DEPTH(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .color_mode(color_mode),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .layer_in(layer_in),
    .invert_in(invert_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblank_out(hblank_out),
    .vblank_out(vblank_out), .invert_active(invert_active)
  );

  // 100 MHz system clock
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic pal_write(input logic [2:0] a, input logic [11:0] d);
    pal_we   = 1'b1;
    pal_addr = a;
    pal_data = d;
    step(1);
    pal_we   = 1'b0;
  endtask

  // Stimulus and checks
  initial begin
    reset = 1'b1; ce_pix = 1'b1; color_mode = 1'b0; pal_we = 1'b0;
    pal_addr = '0; pal_data = '0; layer_in = '0; invert_in = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblank_in = 1'b0; vblank_in = 1'b0;
    step(2);
    chk("reset_rgb",  {r_out, g_out, b_out}, 12'h000);
    chk("reset_sync", {hsync_out, vsync_out, hblank_out, vblank_out}, 4'h0);
    chk("reset_inv",  invert_active, 1'b0);
    reset = 1'b0;

    layer_in = 3'b001; step(2); chk("mono_l0",   {r_out, g_out, b_out}, 12'h777);
    layer_in = 3'b011; step(2); chk("mono_l01",  {r_out, g_out, b_out}, 12'hEEE);
    layer_in = 3'b111; step(2); chk("mono_sat",  {r_out, g_out, b_out}, 12'hFFF);
    layer_in = 3'b000; step(2); chk("mono_none", {r_out, g_out, b_out}, 12'h000);

    pal_write(3'b101, 12'h0FF);
    pal_write(3'b110, 12'hFF0);
    pal_write(3'b111, 12'hABC);
    pal_write(3'b011, 12'h123);
    layer_in = 3'b010; step(2); chk("mono_before_frame", {r_out, g_out, b_out}, 12'h777);
    layer_in = 3'b001; step(2); chk("mono_oob_ignored",  {r_out, g_out, b_out}, 12'h777);

    color_mode = 1'b1; vsync_in = 1'b1; layer_in = 3'b110;
    step(1);
    chk("vsync_d1", vsync_out, 1'b0);
    vsync_in = 1'b0;
    step(1);
    chk("vsync_d2", vsync_out, 1'b1);
    chk("pre_mode_pixel", {r_out, g_out, b_out}, 12'hEEE);
    step(1);
    chk("colour_sat", {r_out, g_out, b_out}, 12'hFFF);
    chk("vsync_d3", vsync_out, 1'b0);
    layer_in = 3'b010; step(2); chk("colour_l1", {r_out, g_out, b_out}, 12'h0FF);

    invert_in = 1'b1; step(1); invert_in = 1'b0;
    chk("inv_not_yet", invert_active, 1'b0);
    layer_in = 3'b000; step(3);
    chk("inv_still_not", invert_active, 1'b0);
    vsync_in = 1'b1; step(1);
    chk("inv_rise", invert_active, 1'b1);
    vsync_in = 1'b0; step(1);
    chk("inv_black_to_white", {r_out, g_out, b_out}, 12'hFFF);
    layer_in = 3'b001; step(2); chk("inv_grey", {r_out, g_out, b_out}, 12'h888);

    hblank_in = 1'b1; step(2);
    chk("hblank_rgb", {r_out, g_out, b_out}, 12'h000);
    chk("hblank_out", hblank_out, 1'b1);
    layer_in = 3'b111; step(1);
    chk("hblank_full_rgb", {r_out, g_out, b_out}, 12'h000);
    layer_in = 3'b001; hblank_in = 1'b0; step(2);
    chk("unblank_rgb", {r_out, g_out, b_out}, 12'h888);
    chk("unblank_out", hblank_out, 1'b0);

    vsync_in = 1'b1; step(1);
    chk("inv_fall", invert_active, 1'b0);
    vsync_in = 1'b0; step(2);
    chk("inv_off_grey", {r_out, g_out, b_out}, 12'h777);

    ce_pix = 1'b0; layer_in = 3'b010; hsync_in = 1'b1; vsync_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        pal_we = 1'b1; pal_addr = 3'b100; pal_data = 12'h123;
      end
      step(1);
      pal_we = 1'b0;
      chk("hold_rgb",  {r_out, g_out, b_out}, 12'h777);
      chk("hold_sync", {hsync_out, vsync_out, invert_active}, 3'b000);
    end
    layer_in = 3'b001; hsync_in = 1'b0; vsync_in = 1'b0; ce_pix = 1'b1;
    step(1); chk("resume_pipe",       {r_out, g_out, b_out}, 12'h777);
    step(1); chk("pal_write_in_hold", {r_out, g_out, b_out}, 12'h123);

    invert_in = 1'b1; step(1); invert_in = 1'b0;
    vsync_in = 1'b1; step(1); vsync_in = 1'b0; step(1);
    chk("pre_reset_inv", invert_active, 1'b1);
    layer_in = 3'b010; step(2);
    chk("pre_reset_rgb", {r_out, g_out, b_out}, 12'hF00);
    #2 reset = 1'b1;
    #1;
    chk("reset_now_rgb", {r_out, g_out, b_out}, 12'h000);
    chk("reset_now_inv", invert_active, 1'b0);
    step(1);
    reset = 1'b0;
    pal_write(3'b101, 12'h0FF);
    step(2);
    chk("post_reset_mono", {r_out, g_out, b_out}, 12'h777);
    vsync_in = 1'b1; step(1); vsync_in = 1'b0; step(2);
    chk("post_reset_colour", {r_out, g_out, b_out}, 12'h0FF);
    chk("post_reset_inv", invert_active, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
